// File: rtl/serial_addsub_n.sv
// ---------------------------------------------------------------------------
// serial_addsub_n
//
// Bit-serial adder/subtractor. Operands arrive LSB first, one A/B bit pair per
// accepted handshake. A start pulse launches an operation. After WIDTH pairs,
// the parallel result, raw carry-out and signed-overflow flags are presented.
// Subtraction is A + ~B + 1. The B stream is inverted on the fly, and the
// running carry is preset to 1 at start.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         launch an operation (honoured only in IDLE or DONE)
//   sub           0 = A+B+carryin, 1 = A-B; sampled with start
//   carryin       add-mode carry-in; sampled with start
//   abort         cancel an operation in RUN
//   bit_valid     a_bit/b_bit hold a valid operand pair
//   a_bit, b_bit  operand bits, LSB first
//   bit_ready     high in RUN; a pair is taken on bit_valid & bit_ready
//   busy          high in RUN
//   sum           result register, filled from the MSB side
//   carryout      carry out of the MSB (subtract: 1 = no borrow)
//   overflow      signed overflow (carry into MSB ^ carry out of MSB)
//   done          one-cycle pulse when the result becomes final
//   result_valid  high from done until the next accepted start
//   bitcount      pairs accepted so far in the current operation
// ---------------------------------------------------------------------------
module serial_addsub_n #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic                       carryin,
  input  logic                       abort,
  input  logic                       bit_valid,
  input  logic                       a_bit,
  input  logic                       b_bit,
  output logic                       bit_ready,
  output logic                       busy,
  output logic [WIDTH-1:0]           sum,
  output logic                       carryout,
  output logic                       overflow,
  output logic                       done,
  output logic                       result_valid,
  output logic [$clog2(WIDTH)-1:0]   bitcount
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   sub_q;    // operation mode latched at start
  logic   carry_q;  // running carry between bit positions

  // One full-adder slice. B is inverted in subtract mode.
  logic b_eff;
  logic sum_bit;
  logic carry_next;
  logic accept;
  logic last_pair;
  logic launch;

  assign b_eff      = b_bit ^ sub_q;
  assign sum_bit    = a_bit ^ b_eff ^ carry_q;
  assign carry_next = (a_bit & b_eff) | (a_bit & carry_q) | (b_eff & carry_q);

  // bit_ready is a registered copy of (state == S_RUN).
  assign accept    = bit_valid & bit_ready;
  assign last_pair = (bitcount == LAST_IDX);

  // A start is honoured only outside RUN. In DONE it takes priority over the
  // DONE -> IDLE fall-through, which gives back-to-back operations.
  assign launch = start & ((state == S_IDLE) || (state == S_DONE));

  // NOTE: every register below is written with non-blocking assignments, so
  //       all right-hand sides see the pre-edge values. The shift of sum and
  //       the carry update therefore use the same, consistent operand set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      sub_q        <= 1'b0;
      carry_q      <= 1'b0;
      sum          <= '0;
      carryout     <= 1'b0;
      overflow     <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
      bitcount     <= '0;
      bit_ready    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // done is a pulse. It is raised only by the final-pair branch.
      done <= 1'b0;

      if (launch) begin
        state        <= S_RUN;
        sub_q        <= sub;
        carry_q      <= sub ? 1'b1 : carryin;
        sum          <= '0;
        bitcount     <= '0;
        result_valid <= 1'b0;
        bit_ready    <= 1'b1;
        busy         <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            // Wait for start. abort has no effect here.
          end

          S_RUN: begin
            if (abort) begin
              state     <= S_IDLE;
              carry_q   <= 1'b0;
              sum       <= '0;
              carryout  <= 1'b0;
              overflow  <= 1'b0;
              bitcount  <= '0;
              bit_ready <= 1'b0;
              busy      <= 1'b0;
            end else if (accept) begin
              sum     <= {sum_bit, sum[WIDTH-1:1]};
              carry_q <= carry_next;
              if (last_pair) begin
                // carry_q is the carry into the MSB at this point.
                carryout     <= carry_next;
                overflow     <= carry_q ^ carry_next;
                bitcount     <= '0;
                state        <= S_DONE;
                done         <= 1'b1;
                result_valid <= 1'b1;
                bit_ready    <= 1'b0;
                busy         <= 1'b0;
              end else begin
                bitcount <= bitcount + 1'b1;
              end
            end
            // bit_valid low: stall, all state held.
          end

          S_DONE: begin
            // DONE lasts exactly one cycle. The results and result_valid hold.
            state <= S_IDLE;
          end

          default: begin
            state     <= S_IDLE;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Structural invariants of the control path
  // -------------------------------------------------------------------------
  done_single_cycle : assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  done_not_busy : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  ready_tracks_busy : assert property (@(posedge clk) disable iff (!rst_n)
    bit_ready == busy);

  busy_tracks_run : assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state == S_RUN));

endmodule
